// File: rtl/spectrum_magnitude_calculator_if.sv
// Streaming bus between the FFT core and the magnitude calculator.
//   fft_dout/fft_valid/fft_last : complex bin stream from the FFT ({imag, real})
//   fft_ready                   : calculator can accept bins
//   magnitude/magnitude_addr    : magnitude estimate and its bin index
//   magnitude_valid             : one-cycle pulse per result
// master = bin producer / result consumer, slave = the calculator.
interface spectrum_magnitude_calculator_if #(
  parameter int unsigned ADDR_WIDTH = 13
);
  logic [31:0]           fft_dout;
  logic                  fft_valid;
  logic                  fft_last;
  logic                  fft_ready;
  logic [15:0]           magnitude;
  logic [ADDR_WIDTH-1:0] magnitude_addr;
  logic                  magnitude_valid;

  modport master (
    output fft_dout, fft_valid, fft_last,
    input  fft_ready, magnitude, magnitude_addr, magnitude_valid
  );

  modport slave (
    input  fft_dout, fft_valid, fft_last,
    output fft_ready, magnitude, magnitude_addr, magnitude_valid
  );
endinterface

// File: rtl/spectrum_magnitude_calculator.sv
// Streaming alpha-max-plus-3/8-beta-min magnitude estimator, 3-stage pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   fft_bus    : slave side of spectrum_magnitude_calculator_if
//                (bins in, tagged magnitudes out, fixed 3-clock latency)
module spectrum_magnitude_calculator #(
  parameter int unsigned FFT_POINTS = 8192,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                           clk,
  input  logic                           rst_n,
  spectrum_magnitude_calculator_if.slave fft_bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(FFT_POINTS - 1);

  logic                  ready_q;
  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [15:0]           re_c, im_c, re_abs_c, im_abs_c;
  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [15:0]           s1_re_q, s1_im_q;

  logic [15:0]           max_d, min_d;
  logic                  s2_valid_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic [15:0]           s2_max_q, s2_min_q;

  logic [15:0]           mag_d;
  logic                  mag_valid_q;
  logic [ADDR_WIDTH-1:0] mag_addr_q;
  logic [15:0]           mag_q;

  // No backpressure: every valid cycle after reset is an accepted bin.
  assign accept_c = fft_bus.fft_valid & ready_q;

  // Unsigned absolute values; -32768 maps to 32768 since the result is unsigned.
  assign re_c     = fft_bus.fft_dout[15:0];
  assign im_c     = fft_bus.fft_dout[31:16];
  assign re_abs_c = re_c[15] ? 16'(~re_c + 16'd1) : re_c;
  assign im_abs_c = im_c[15] ? 16'(~im_c + 16'd1) : im_c;

  // Bin counter: wraps on fft_last or at the last bin of the frame.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c) begin
      if (fft_bus.fft_last || (cnt_q == LAST_BIN)) cnt_d = '0;
      else                                        cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Stage 2 compare and stage 3 shift-add (max 45056, fits 16 bits).
  always_comb begin
    max_d = (s1_re_q >= s1_im_q) ? s1_re_q : s1_im_q;
    min_d = (s1_re_q >= s1_im_q) ? s1_im_q : s1_re_q;
    mag_d = s2_max_q + (s2_min_q >> 2) + (s2_min_q >> 3);
  end

  // Pipeline shifts every cycle; output data only updates on a valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_max_q    <= '0;
      s2_min_q    <= '0;
      mag_valid_q <= 1'b0;
      mag_addr_q  <= '0;
      mag_q       <= '0;
    end else begin
      ready_q     <= 1'b1;
      cnt_q       <= cnt_d;
      s1_valid_q  <= accept_c;
      s1_addr_q   <= cnt_q;
      s1_re_q     <= re_abs_c;
      s1_im_q     <= im_abs_c;
      s2_valid_q  <= s1_valid_q;
      s2_addr_q   <= s1_addr_q;
      s2_max_q    <= max_d;
      s2_min_q    <= min_d;
      mag_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        mag_addr_q <= s2_addr_q;
        mag_q      <= mag_d;
      end
    end
  end

  assign fft_bus.fft_ready       = ready_q;
  assign fft_bus.magnitude       = mag_q;
  assign fft_bus.magnitude_addr  = mag_addr_q;
  assign fft_bus.magnitude_valid = mag_valid_q;

endmodule

// File: tb/tb_spectrum_magnitude_calculator.sv
// Bench for spectrum_magnitude_calculator: randomized bins against an
// arithmetic reference model with cycle-stamped expected results.
module tb_spectrum_magnitude_calculator;
  localparam int unsigned FFT_POINTS = 8192;
  localparam int unsigned ADDR_WIDTH = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spectrum_magnitude_calculator_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  spectrum_magnitude_calculator #(
    .FFT_POINTS(FFT_POINTS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fft_bus(bus)
  );

  typedef struct {
    longint stamp;
    int     mag;
    int     addr;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc      = 0;
  int     mdl_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_mag(input int re, input int im);
    int a, b, mx, mn;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
  endfunction

  // One accepted bin; its result is due 3 clocks after the sampling edge's drive cycle.
  task automatic send_bin(input int re, input int im, input bit last);
    exp_t e;
    @(negedge clk);
    bus.fft_dout  = {16'(im), 16'(re)};
    bus.fft_valid = 1'b1;
    bus.fft_last  = last;
    e.stamp = cyc + 3;
    e.mag   = ref_mag(re, im);
    e.addr  = mdl_addr;
    exp_q.push_back(e);
    mdl_addr = (last || mdl_addr == int'(FFT_POINTS - 1)) ? 0 : mdl_addr + 1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'($urandom_range(0, 1));
    bus.fft_dout  = $urandom;
  endtask

  task automatic send_rand(input bit last);
    send_bin(int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768, last);
  endtask

  // Output monitor: a pulse is required exactly when a result is due.
  always @(negedge clk) begin
    logic due;
    due = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
    check("valid", 32'(bus.magnitude_valid), 32'(due));
    if (due) begin
      check("mag",  32'(bus.magnitude),      32'(exp_q[0].mag));
      check("addr", 32'(bus.magnitude_addr), 32'(exp_q[0].addr));
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.fft_dout  = '0;
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mag",   32'(bus.magnitude),       0);
    check("rst_addr",  32'(bus.magnitude_addr),  0);
    check("rst_valid", 32'(bus.magnitude_valid), 0);
    check("rst_ready", 32'(bus.fft_ready),       0);
    rst_n = 1'b1;
    #1 check("ready_pre", 32'(bus.fft_ready), 0);
    @(negedge clk);
    check("ready_post", 32'(bus.fft_ready), 1);

    // Directed vectors; the first is isolated, the last closes the frame
    send_bin(3000, 4000, 1'b0);
    repeat (5) idle();
    send_bin(-32768, 0, 1'b0);
    send_bin(-32768, -32768, 1'b0);
    send_bin(-1, 1, 1'b0);
    send_bin(0, 0, 1'b1);
    repeat (4) idle();

    // Full frame, continuous valid, last on the final bin, then next frame
    for (int i = 0; i < int'(FFT_POINTS); i++) send_rand(i == int'(FFT_POINTS - 1));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send_rand(1'b0);
    end

    // Reset mid-frame with results in flight
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_addr = 0;
    bus.fft_valid = 1'b0;
    #1 check("midrst_valid", 32'(bus.magnitude_valid), 0);
    check("midrst_ready", 32'(bus.fft_ready), 0);
    check("midrst_mag",   32'(bus.magnitude), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready1", 32'(bus.fft_ready), 1);

    // Early last on bin 99
    for (int i = 0; i < 100; i++) send_rand(i == 99);
    repeat (2) idle();

    // FFT_POINTS+1 bins without last wrap back to 0, with a few gaps
    for (int i = 0; i < int'(FFT_POINTS) + 1; i++) begin
      if ($urandom_range(0, 15) == 0) idle();
      send_rand(1'b0);
    end
    for (int i = 0; i < 3; i++) send_rand(1'b0);

    // Drain
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle();
    idle();
    check("drain", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
